arrow_scroller: RTL and testbench

ARROW_SCROLLER -- requirements
Module: arrow_scroller

---
 rtl/arrow_scroller.sv | 231 +++++++++++++++++++++++
 tb/tb_arrow_scroller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arrow_scroller.sv
`default_nettype none
// ============================================================================
// Module      : arrow_scroller
// Description : Rhythm-game arrow field. Scrolls 26 three-bit slots downward
//               once per step, fetches new arrow codes from a song source,
//               judges player presses against the hit zone (slots 23..25),
//               reports misses, and keeps a saturating score.
// Revision    : 1.0 - initial release
// ============================================================================
module arrow_scroller #(
  parameter int STEP_CYCLES = 1666667,
  parameter int IND_HOLD    = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        arrow_req,
  input  logic        arrow_valid,
  input  logic [2:0]  arrow_code,
  input  logic        song_end,
  input  logic        press_valid,
  input  logic [2:0]  press_code,
  output logic [77:0] arrow_array,
  output logic [1:0]  indicator,
  output logic [15:0] score,
  output logic        busy
);

  localparam int               c_CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [c_CW-1:0]  c_LAST      = c_CW'(STEP_CYCLES - 1);
  localparam int               c_HW        = (IND_HOLD > 1) ? $clog2(IND_HOLD) : 1;
  localparam logic [c_HW-1:0]  c_HOLD_LAST = c_HW'(IND_HOLD - 1);

  localparam logic [1:0] c_IND_NONE = 2'b00;
  localparam logic [1:0] c_IND_BAD  = 2'b01;
  localparam logic [1:0] c_IND_GOOD = 2'b10;
  localparam logic [1:0] c_IND_EXC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [77:0]       r_arr;
  logic              r_pend_valid;
  logic [2:0]        r_pend_code;
  logic              r_req;
  logic [1:0]        r_ind;
  logic [c_HW-1:0]   r_ind_cnt;
  logic [15:0]       r_score;

  logic              w_active;
  logic              w_step;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_end;
  logic [2:0]        w_code_in;
  logic              w_press_ok;
  logic [2:0]        w_s23;
  logic [2:0]        w_s24;
  logic [2:0]        w_s25;
  logic              w_hit;
  logic              w_hit_exc;
  logic [4:0]        w_hit_slot;
  logic              w_miss;
  logic [4:0]        w_clr_pos;
  logic [6:0]        w_clr_base;
  logic              w_clr_en;
  logic [77:0]       w_arr_nxt;
  logic              w_arr_zero;
  logic [16:0]       w_sum;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_step     = w_active && (r_cnt == c_LAST);
  assign w_start_ok = start && !w_active;
  assign w_accept   = (r_state == S_RUN) && r_req && arrow_valid;
  assign w_end      = w_accept && song_end;

  // Codes 101 and 111 are undefined lanes and become empty slots.
  assign w_code_in  = ((arrow_code == 3'b101) || (arrow_code == 3'b111)) ? 3'b000 : arrow_code;

  // A press only counts when it names a real lane.
  assign w_press_ok = w_active && press_valid && (press_code != 3'b000) &&
                      (press_code != 3'b101) && (press_code != 3'b111);

  assign w_s23 = r_arr[71:69];
  assign w_s24 = r_arr[74:72];
  assign w_s25 = r_arr[77:75];

  // Judge against pre-shift contents: slot 24 is dead centre, 25 then 23 are near misses.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_exc  = 1'b0;
    w_hit_slot = 5'd0;
    if (w_press_ok) begin
      if (w_s24 == press_code) begin
        w_hit      = 1'b1;
        w_hit_exc  = 1'b1;
        w_hit_slot = 5'd24;
      end else if (w_s25 == press_code) begin
        w_hit      = 1'b1;
        w_hit_slot = 5'd25;
      end else if (w_s23 == press_code) begin
        w_hit      = 1'b1;
        w_hit_slot = 5'd23;
      end
    end
  end

  // An arrow leaving slot 25 is a miss unless this very press just hit it.
  assign w_miss = w_step && (w_s25 != 3'b000) && !(w_hit && (w_hit_slot == 5'd25));

  // The hit arrow moves one row down when the press lands on a step edge.
  assign w_clr_pos  = w_step ? (w_hit_slot + 5'd1) : w_hit_slot;
  assign w_clr_base = {2'b00, w_clr_pos} * 7'd3;
  assign w_clr_en   = w_hit && !(w_step && (w_hit_slot == 5'd25));

  // Next array: shift on step, then remove the arrow that was hit.
  always_comb begin
    w_arr_nxt = r_arr;
    if (w_step) begin
      w_arr_nxt = {r_arr[74:0], (r_pend_valid ? r_pend_code : 3'b000)};
    end
    if (w_clr_en) begin
      w_arr_nxt[w_clr_base +: 3] = 3'b000;
    end
  end

  assign w_arr_zero = (w_arr_nxt == 78'd0);
  assign w_sum      = {1'b0, r_score} + (w_hit_exc ? 17'd3 : (w_hit ? 17'd1 : 17'd0));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start only from IDLE/DONE, drain until the field is empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)                  w_state_nxt = S_RUN;
      S_RUN:          if (w_end)                  w_state_nxt = S_DRAIN;
      S_DRAIN:        if (w_step && w_arr_zero)   w_state_nxt = S_DONE;
      default:                                    w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: step counter, field, fetch handshake, judgement, score.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_arr        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= 3'b000;
      r_req        <= 1'b0;
      r_ind        <= c_IND_NONE;
      r_ind_cnt    <= '0;
      r_score      <= 16'd0;
    end else if (w_start_ok) begin
      r_cnt        <= '0;
      r_arr        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= 3'b000;
      r_req        <= 1'b1;
      r_ind        <= c_IND_NONE;
      r_ind_cnt    <= '0;
      r_score      <= 16'd0;
    end else if (w_active) begin
      r_cnt <= w_step ? '0 : (r_cnt + 1'b1);
      r_arr <= w_arr_nxt;

      // A code accepted on a step edge survives for the following step.
      if (w_end) begin
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_code  <= w_code_in;
      end else if (w_step) begin
        r_pend_valid <= 1'b0;
      end

      // Request stays up across a step when the source has not answered.
      if (w_accept) begin
        r_req <= 1'b0;
      end else if (w_step && (r_state == S_RUN)) begin
        r_req <= 1'b1;
      end

      if (w_hit) begin
        r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end

      // Press result outranks a simultaneous miss; otherwise decay per step.
      if (w_press_ok) begin
        r_ind     <= w_hit_exc ? c_IND_EXC : (w_hit ? c_IND_GOOD : c_IND_BAD);
        r_ind_cnt <= '0;
      end else if (w_miss) begin
        r_ind     <= c_IND_BAD;
        r_ind_cnt <= '0;
      end else if (w_step && (r_ind != c_IND_NONE)) begin
        if (r_ind_cnt == c_HOLD_LAST) begin
          r_ind     <= c_IND_NONE;
          r_ind_cnt <= '0;
        end else begin
          r_ind_cnt <= r_ind_cnt + 1'b1;
        end
      end
    end else begin
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_pend_valid <= 1'b0;
    end
  end

  assign arrow_req   = r_req;
  assign arrow_array = r_arr;
  assign indicator   = r_ind;
  assign score       = r_score;
  assign busy        = w_active;

endmodule
`default_nettype wire

// File: tb/tb_arrow_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_arrow_scroller
// Description : Directed self-checking bench for arrow_scroller with
//               STEP_CYCLES=4 and IND_HOLD=2. A song-source responder answers
//               arrow requests from a fixed feed list; one fetch is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arrow_scroller;

  localparam int c_STALL_IDX = 31;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        arrow_req;
  logic        arrow_valid;
  logic [2:0]  arrow_code;
  logic        song_end;
  logic        press_valid;
  logic [2:0]  press_code;
  logic [77:0] arrow_array;
  logic [1:0]  indicator;
  logic [15:0] score;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   fetch_idx = 0;
  logic stall_en;

  arrow_scroller #(
    .STEP_CYCLES (4),
    .IND_HOLD    (2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .arrow_req   (arrow_req),
    .arrow_valid (arrow_valid),
    .arrow_code  (arrow_code),
    .song_end    (song_end),
    .press_valid (press_valid),
    .press_code  (press_code),
    .arrow_array (arrow_array),
    .indicator   (indicator),
    .score       (score),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Song feed: fetch k supplies the arrow inserted at step k+1.
  function automatic logic [2:0] feed_code(input int idx);
    case (idx)
      0:       return 3'b010;
      1:       return 3'b011;
      3:       return 3'b100;
      30:      return 3'b110;
      31:      return 3'b011;
      default: return (idx >= 32) ? 3'b001 : 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] slot(input int i);
    return arrow_array[3*i +: 3];
  endfunction

  task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Song-source responder: answers a request immediately unless stalled.
  initial begin
    arrow_valid = 1'b0;
    arrow_code  = 3'b000;
    song_end    = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (arrow_req && !(stall_en && fetch_idx == c_STALL_IDX)) begin
        arrow_valid = 1'b1;
        arrow_code  = feed_code(fetch_idx);
        song_end    = (fetch_idx == c_STALL_IDX);
        fetch_idx++;
      end else begin
        arrow_valid = 1'b0;
        song_end    = 1'b0;
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    press_valid = 1'b0;
    press_code  = 3'b000;
    stall_en    = 1'b1;
    #2;
    chk("rst_array", arrow_array, 78'd0);
    chk("rst_ind",   indicator, 2'b00);
    chk("rst_score", score, 16'd0);
    chk("rst_req",   arrow_req, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    chk("idle_busy", busy, 1'b0);
    chk("idle_req",  arrow_req, 1'b0);

    // Start; steps then land every 4 cycles after this point.
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("step1_slot0", slot(0), 3'b010);
    chk("step1_slot1", slot(1), 3'b000);
    chk("run_busy",    busy, 1'b1);
    chk("run_score",   score, 16'd0);
    cyc(96);
    chk("step25_slot24", slot(24), 3'b010);
    chk("step25_slot23", slot(23), 3'b011);
    chk("step25_slot25", slot(25), 3'b000);

    // Excellent hit on slot 24.
    press_valid = 1'b1; press_code = 3'b010; cyc(1); press_valid = 1'b0;
    chk("exc_ind",    indicator, 2'b11);
    chk("exc_score",  score, 16'd3);
    chk("exc_slot24", slot(24), 3'b000);
    chk("exc_slot23", slot(23), 3'b011);
    cyc(3);
    chk("hold_ind", indicator, 2'b11);
    cyc(4);
    chk("decay_ind", indicator, 2'b00);
    chk("pre_miss_slot25", slot(25), 3'b011);

    // Unhit 011 falls off.
    cyc(4);
    chk("miss_ind",    indicator, 2'b01);
    chk("miss_score",  score, 16'd3);
    chk("miss_slot25", slot(25), 3'b000);
    cyc(4);
    chk("pre_good_slot25", slot(25), 3'b100);

    // Press coinciding with a step, arrow in slot 25.
    cyc(3);
    press_valid = 1'b1; press_code = 3'b100; cyc(1); press_valid = 1'b0;
    chk("good_ind",    indicator, 2'b10);
    chk("good_score",  score, 16'd4);
    chk("good_slot25", slot(25), 3'b000);

    // Fetch 31 is stalled across step 32.
    cyc(8);
    chk("stall_req",   arrow_req, 1'b1);
    chk("stall_slot0", slot(0), 3'b000);
    chk("stall_slot1", slot(1), 3'b110);
    stall_en = 1'b0;
    cyc(1);
    chk("drain_busy", busy, 1'b1);
    chk("drain_req",  arrow_req, 1'b0);

    // start must be ignored while draining.
    cyc(10);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("drain_start_slot4", slot(4), 3'b110);
    chk("drain_start_busy",  busy, 1'b1);
    cyc(84);
    chk("drain_slot25", slot(25), 3'b110);
    chk("drain_busy2",  busy, 1'b1);
    cyc(4);
    chk("done_busy",  busy, 1'b0);
    chk("done_array", arrow_array, 78'd0);
    chk("done_score", score, 16'd4);
    chk("done_ind",   indicator, 2'b01);

    // Restart from DONE, then asynchronous reset mid-song.
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("re_slot0", slot(0), 3'b001);
    chk("re_score", score, 16'd0);
    chk("re_ind",   indicator, 2'b00);
    chk("re_busy",  busy, 1'b1);
    chk("re_req",   arrow_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_array", arrow_array, 78'd0);
    chk("arst_ind",   indicator, 2'b00);
    chk("arst_score", score, 16'd0);
    chk("arst_req",   arrow_req, 1'b0);
    chk("arst_busy",  busy, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    cyc(5);
    chk("post_rst_busy",  busy, 1'b0);
    chk("post_rst_req",   arrow_req, 1'b0);
    chk("post_rst_array", arrow_array, 78'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
